remove_header: RTL and testbench
================================

# remove_header

Egress-side inverse of the ingress header insertion. Consumes packets on the 64-bit internal datapath whose leading words are module headers (nonzero ctrl before the first data word). Drops every header word and forwards the Ethernet payload words plus EOP word unchanged. Captures the IO-queue header fields (source port, word length, byte length) into a sideband register for the output-port logic and MAC wrapper.

## Interface
- DATA_WIDTH, 64, datapath width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl width.
- IOQ_CTRL, 8'hFF, ctrl value identifying the IO-queue header word.
- SRC_PORT_POS, 16, LSB of 16-bit source-port field (byte length occupies [15:0]).
- WORD_LEN_POS, 32, LSB of 16-bit word-length field.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_data  in  DATA_WIDTH  upstream word.
- in_ctrl  in  CTRL_WIDTH  upstream ctrl.
- in_wr  in  1  upstream word valid.
- in_rdy  out  1  block can accept a word.
- out_data  out  DATA_WIDTH  forwarded word (registered).
- out_ctrl  out  CTRL_WIDTH  forwarded ctrl (registered).
- out_wr  out  1  forwarded word valid (registered).
- out_rdy  in  1  downstream has room for at least 2 words.
- hdr_src_port  out  16  source port of last IOQ header.
- hdr_word_len  out  16  word length of last IOQ header.
- hdr_byte_len  out  16  byte length of last IOQ header.
- hdr_valid  out  1  one-cycle pulse on IOQ header capture.
- hdr_missing  out  1  one-cycle pulse: packet entered data phase with no IOQ header seen.
- pkt_count  out  32  forwarded-packet count (see Configuration).
- hdr_drop_count  out  32  dropped header-word count (see Configuration).

## Operation
- Accept condition: in_wr && in_rdy; in_rdy = out_rdy (combinational).
- States: HDR (reset state, between packets), DATA.
- HDR, accepted word with in_ctrl != 0: header word; dropped, out_wr stays 0. If in_ctrl == IOQ_CTRL: load hdr_src_port = in_data[SRC_PORT_POS+:16], hdr_word_len = in_data[WORD_LEN_POS+:16], hdr_byte_len = in_data[15:0]; set seen_ioq; pulse hdr_valid next cycle. Multiple header words allowed, any order; last IOQ header wins.
- HDR, accepted word with in_ctrl == 0: first data word; forwarded; go to DATA. If seen_ioq clear, pulse hdr_missing. Clear seen_ioq.
- DATA, accepted word with in_ctrl == 0: forwarded.
- DATA, accepted word with in_ctrl != 0: EOP; forwarded with ctrl unchanged; go to HDR.
- Non-accepted cycles: no state change, out_wr = 0.
- Every packet has at least one ctrl == 0 word; all nonzero-ctrl words in HDR are treated as headers.
- hdr_* fields hold until next IOQ header.

## Timing
- Latency: accepted word appears on out_* exactly 1 cycle later with out_wr = 1.
- out_wr never asserted more than 1 cycle after out_rdy deasserts; 2-word out_rdy margin covers the registered word.
- in_rdy low blocks acceptance even with in_wr high; word must be held upstream.
- hdr_valid / hdr_missing registered, asserted same cycle as the output word (or header drop) they relate to.
- Reset values: out_data 0, out_ctrl 0, out_wr 0, hdr_* 0, hdr_valid 0, hdr_missing 0, counters 0, state HDR, seen_ioq 0.
- Reset mid-packet: state returns to HDR; remaining words of the partial packet are interpreted as a new packet (upstream is reset together).
- Back-to-back packets: EOP and next packet's first header word in consecutive cycles supported, no bubble.

## Configuration
- REMOVE_HEADER_STATS_EN defined: pkt_count increments (wraps at 2^32) on each forwarded EOP; hdr_drop_count increments on each dropped header word. Cleared by reset.
- Undefined: counter logic absent; pkt_count and hdr_drop_count tied to 0.

## Test plan
- IOQ header {word_len 3, src_port 2, byte_len 20}, ctrl FF, then data D0,D1 (ctrl 0), EOP D2 ctrl 0x10 -> out D0,D1,D2 with ctrls 0,0,0x10 one cycle after each accept; hdr_src_port 2, hdr_word_len 3, hdr_byte_len 20, hdr_valid one pulse, no header on output.
- Two header words (ctrl 0x42 then ctrl FF src_port 5) before data -> both dropped, hdr_src_port 5, hdr_drop_count 2 with STATS_EN.
- Packet with no IOQ header (ctrl 0x42 only) -> data forwarded, hdr_missing pulses once, hdr_* unchanged.
- out_rdy deasserted mid-packet for 4 cycles -> in_rdy low those cycles, no words lost or duplicated, out_wr 0 after one cycle.
- Back-to-back 3 packets, EOP followed immediately by header -> 3 packets out intact, pkt_count 3 with STATS_EN, 0 without.
- reset asserted in DATA after D0 -> outputs 0 next cycle; following header+packet forwarded correctly.

Source files
------------

// File: rtl/remove_header.sv
// remove_header: egress-side header stripper for the 64-bit internal datapath.
// Drops every leading header word (nonzero ctrl before the first data word).
// Forwards payload words and the EOP word unchanged, one cycle after accept.
// Fields of the last IO-queue header are latched into a sideband register.
// Optional statistics counters are built when REMOVE_HEADER_STATS_EN is defined;
// otherwise pkt_count and hdr_drop_count are tied to zero.
module remove_header #(
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    CTRL_WIDTH   = DATA_WIDTH/8,
    parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL     = 8'hFF,
    parameter int                    SRC_PORT_POS = 16,
    parameter int                    WORD_LEN_POS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [15:0]           hdr_src_port,
    output logic [15:0]           hdr_word_len,
    output logic [15:0]           hdr_byte_len,
    output logic                  hdr_valid,
    output logic                  hdr_missing,
    output logic [31:0]           pkt_count,
    output logic [31:0]           hdr_drop_count
);

    localparam logic [0:0] ST_HDR  = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;

    logic [0:0] state;
    logic       seen_ioq;
    logic       accept;
    logic       is_hdr;
    logic       is_eop;

    // Downstream guarantees room for two words, so the single output register
    // never overflows when acceptance simply follows out_rdy.
    assign in_rdy = out_rdy;
    assign accept = in_wr && out_rdy;
    assign is_hdr = (state == ST_HDR)  && (in_ctrl != '0);
    assign is_eop = (state == ST_DATA) && (in_ctrl != '0);

    // Packet-phase tracking, output register and header sideband capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_HDR;
            seen_ioq     <= 1'b0;
            out_data     <= '0;
            out_ctrl     <= '0;
            out_wr       <= 1'b0;
            hdr_src_port <= '0;
            hdr_word_len <= '0;
            hdr_byte_len <= '0;
            hdr_valid    <= 1'b0;
            hdr_missing  <= 1'b0;
        end else begin
            out_wr      <= 1'b0;
            hdr_valid   <= 1'b0;
            hdr_missing <= 1'b0;
            if (accept) begin
                if (is_hdr) begin
                    // Header words are swallowed; only the IOQ header is kept,
                    // and a later IOQ header in the same packet overrides.
                    if (in_ctrl == IOQ_CTRL) begin
                        hdr_src_port <= in_data[SRC_PORT_POS +: 16];
                        hdr_word_len <= in_data[WORD_LEN_POS +: 16];
                        hdr_byte_len <= in_data[15:0];
                        hdr_valid    <= 1'b1;
                        seen_ioq     <= 1'b1;
                    end
                end else begin
                    out_data <= in_data;
                    out_ctrl <= in_ctrl;
                    out_wr   <= 1'b1;
                    if (state == ST_HDR) begin
                        state       <= ST_DATA;
                        hdr_missing <= !seen_ioq;
                        seen_ioq    <= 1'b0;
                    end else if (is_eop) begin
                        state <= ST_HDR;
                    end
                end
            end
        end
    end

`ifdef REMOVE_HEADER_STATS_EN
    // Statistics: forwarded packets (counted at EOP) and dropped header words.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count      <= '0;
            hdr_drop_count <= '0;
        end else if (accept) begin
            if (is_hdr)
                hdr_drop_count <= hdr_drop_count + 32'd1;
            else if (is_eop)
                pkt_count <= pkt_count + 32'd1;
        end
    end
`else
    assign pkt_count      = '0;
    assign hdr_drop_count = '0;
`endif

endmodule

// File: tb/tb_remove_header.sv
// Testbench for remove_header: randomized packet stream checked every cycle
// against a packet-level reference model, plus literal checks on known packets.
module tb_remove_header;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic [15:0] hdr_src_port, hdr_word_len, hdr_byte_len;
    logic        hdr_valid, hdr_missing;
    logic [31:0] pkt_count, hdr_drop_count;

    remove_header dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .hdr_src_port(hdr_src_port), .hdr_word_len(hdr_word_len), .hdr_byte_len(hdr_byte_len),
        .hdr_valid(hdr_valid), .hdr_missing(hdr_missing),
        .pkt_count(pkt_count), .hdr_drop_count(hdr_drop_count)
    );

    always #5 clk = ~clk;

`ifdef REMOVE_HEADER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // role: 0 plain header, 1 IOQ header, 2 data, 3 EOP; miss marks a first
    // data word of a packet that carried no IOQ header.
    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
        int          role;
        bit          miss;
    } word_t;

    word_t q[$];
    word_t log_q[$];
    word_t w;

    int total = 0;
    int bad   = 0;
    bit rnd     = 1'b0;
    int stall   = 0;
    bit started = 1'b0;
    int fwd_cnt = 0;
    int hv_pulses = 0;
    int hm_pulses = 0;

    // expected DUT outputs after the most recent edge
    logic        e_wr, e_hv, e_hm;
    logic [63:0] e_d;
    logic [7:0]  e_c;
    logic [15:0] e_src, e_wl, e_bl;
    logic [31:0] e_pkt, e_drop;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push_w(input logic [63:0] d, input logic [7:0] c, input int role, input bit miss);
        word_t x;
        x.d = d; x.c = c; x.role = role; x.miss = miss;
        q.push_back(x);
    endtask

    function automatic logic [63:0] ioq_word(input logic [15:0] wl, input logic [15:0] sp,
                                             input logic [15:0] bl);
        return {16'h0, wl, sp, bl};
    endfunction

    // Random packet; returns the number of words that must come out.
    task automatic push_pkt(input int nh, input int nd, output int nout);
        bit ioq = 1'b0;
        for (int h = 0; h < nh; h++) begin
            if ($urandom_range(0, 1) == 1) begin
                push_w(ioq_word(16'($urandom), 16'($urandom), 16'($urandom)), 8'hFF, 1, 1'b0);
                ioq = 1'b1;
            end else begin
                push_w({$urandom, $urandom}, 8'($urandom_range(1, 254)), 0, 1'b0);
            end
        end
        for (int i = 0; i < nd; i++)
            push_w({$urandom, $urandom}, 8'h00, 2, (i == 0) && !ioq);
        push_w({$urandom, $urandom}, 8'($urandom_range(1, 255)), 3, 1'b0);
        nout = nd + 1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d words left, want 0", q.size());
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Upstream driver: presents the queue head, holds it until accepted.
    always @(negedge clk) begin
        if (stall > 0) begin
            out_rdy = 1'b0;
            stall--;
        end else begin
            out_rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (q.size() > 0 && (!rnd || $urandom_range(0, 4) != 0)) begin
            in_wr = 1'b1; in_data = q[0].d; in_ctrl = q[0].c;
        end else begin
            in_wr = 1'b0; in_data = {$urandom, $urandom}; in_ctrl = 8'($urandom);
        end
    end

    // Reference model: each accepted word is judged by its known role.
    always @(posedge clk) begin
        if (reset) begin
            started = 1'b1;
            e_wr = 0; e_hv = 0; e_hm = 0; e_d = 0; e_c = 0;
            e_src = 0; e_wl = 0; e_bl = 0; e_pkt = 0; e_drop = 0;
            q.delete();
        end else if (started) begin
            e_wr = 0; e_hv = 0; e_hm = 0;
            chk("in_rdy", 64'(in_rdy), 64'(out_rdy));
            if (in_wr && out_rdy && q.size() > 0) begin
                w = q.pop_front();
                if (w.role <= 1) begin
                    e_drop++;
                    if (w.role == 1) begin
                        e_hv = 1; e_bl = w.d[15:0]; e_src = w.d[31:16]; e_wl = w.d[47:32];
                    end
                end else begin
                    e_wr = 1; e_d = w.d; e_c = w.c; e_hm = w.miss;
                    fwd_cnt++;
                    if (w.role == 3) e_pkt++;
                end
            end
        end
    end

    // Compare process: outputs against the model every cycle.
    always @(negedge clk) begin
        if (started) begin
            chk("out_wr", 64'(out_wr), 64'(e_wr));
            if (e_wr || reset) begin
                chk("out_data", out_data, e_d);
                chk("out_ctrl", 64'(out_ctrl), 64'(e_c));
            end
            chk("hdr_valid", 64'(hdr_valid), 64'(e_hv));
            chk("hdr_missing", 64'(hdr_missing), 64'(e_hm));
            chk("hdr_src_port", 64'(hdr_src_port), 64'(e_src));
            chk("hdr_word_len", 64'(hdr_word_len), 64'(e_wl));
            chk("hdr_byte_len", 64'(hdr_byte_len), 64'(e_bl));
            chk("pkt_count", 64'(pkt_count), STATS ? 64'(e_pkt) : 64'd0);
            chk("hdr_drop_count", 64'(hdr_drop_count), STATS ? 64'(e_drop) : 64'd0);
            if (out_wr === 1'b1) begin
                w.d = out_data; w.c = out_ctrl; w.role = 2; w.miss = 1'b0;
                log_q.push_back(w);
            end
            hv_pulses += int'(hdr_valid);
            hm_pulses += int'(hdr_missing);
        end
    end

    initial begin
        int n, nout, hv0, hm0, f0;
        logic [31:0] pk0;
        reset = 1'b1; in_wr = 0; in_data = 0; in_ctrl = 0; out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_wr", 64'(out_wr), 64'd0);
        chk("rst_hdr_src", 64'(hdr_src_port), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // IOQ header {word_len 3, src 2, byte_len 20} then D0, D1, EOP D2.
        log_q.delete(); hv0 = hv_pulses;
        push_w(ioq_word(16'd3, 16'd2, 16'd20), 8'hFF, 1, 1'b0);
        push_w(64'hD0, 8'h00, 2, 1'b0);
        push_w(64'hD1, 8'h00, 2, 1'b0);
        push_w(64'hD2, 8'h10, 3, 1'b0);
        drain();
        chk("p1_len", 64'(log_q.size()), 64'd3);
        if (log_q.size() == 3) begin
            chk("p1_d0", log_q[0].d, 64'hD0); chk("p1_c0", 64'(log_q[0].c), 64'h0);
            chk("p1_d1", log_q[1].d, 64'hD1); chk("p1_c1", 64'(log_q[1].c), 64'h0);
            chk("p1_d2", log_q[2].d, 64'hD2); chk("p1_c2", 64'(log_q[2].c), 64'h10);
        end
        chk("p1_src", 64'(hdr_src_port), 64'd2);
        chk("p1_wlen", 64'(hdr_word_len), 64'd3);
        chk("p1_blen", 64'(hdr_byte_len), 64'd20);
        chk("p1_hv_pulses", 64'(hv_pulses - hv0), 64'd1);

        // Two header words, IOQ last: both dropped, src_port 5.
        push_w(64'h1234, 8'h42, 0, 1'b0);
        push_w(ioq_word(16'd7, 16'd5, 16'd64), 8'hFF, 1, 1'b0);
        push_w(64'hA0, 8'h00, 2, 1'b0);
        push_w(64'hA1, 8'h01, 3, 1'b0);
        drain();
        chk("p2_src", 64'(hdr_src_port), 64'd5);
        chk("p2_drops", 64'(hdr_drop_count), STATS ? 64'd3 : 64'd0);

        // No IOQ header: hdr_missing once, sideband unchanged.
        hm0 = hm_pulses;
        push_w(64'h55, 8'h42, 0, 1'b0);
        push_w(64'hB0, 8'h00, 2, 1'b1);
        push_w(64'hB1, 8'h02, 3, 1'b0);
        drain();
        chk("p3_hm_pulses", 64'(hm_pulses - hm0), 64'd1);
        chk("p3_src_hold", 64'(hdr_src_port), 64'd5);

        // Downstream stall of 4 cycles mid-packet.
        log_q.delete();
        push_w(ioq_word(16'd8, 16'd1, 16'd50), 8'hFF, 1, 1'b0);
        for (int i = 0; i < 6; i++) push_w(64'hC0 + 64'(i), 8'h00, 2, 1'b0);
        push_w(64'hCF, 8'h20, 3, 1'b0);
        repeat (3) @(negedge clk);
        stall = 4;
        drain();
        chk("stall_len", 64'(log_q.size()), 64'd7);
        if (log_q.size() == 7) chk("stall_last", log_q[6].d, 64'hCF);

        // Three back-to-back packets.
        log_q.delete(); pk0 = pkt_count; n = 0;
        for (int p = 0; p < 3; p++) begin
            push_pkt(1 + p, 2, nout);
            n += nout;
        end
        drain();
        chk("b2b_pkts", 64'(pkt_count - pk0), STATS ? 64'd3 : 64'd0);
        chk("b2b_words", 64'(log_q.size()), 64'(n));

        // Randomized traffic with random valid/ready.
        rnd = 1'b1;
        for (int p = 0; p < 150; p++) push_pkt($urandom_range(0, 3), $urandom_range(1, 4), nout);
        drain();
        rnd = 1'b0;

        // Reset in the data phase after the first data word.
        f0 = fwd_cnt;
        push_w(ioq_word(16'd4, 16'd9, 16'd30), 8'hFF, 1, 1'b0);
        for (int i = 0; i < 3; i++) push_w(64'hE0 + 64'(i), 8'h00, 2, 1'b0);
        push_w(64'hEF, 8'h04, 3, 1'b0);
        n = 0;
        while (fwd_cnt == f0 && n < 50) begin @(negedge clk); n++; end
        if (fwd_cnt == f0) begin
            total++; bad++;
            $display("FAIL rst_wait_timeout: fwd_cnt %0d want > %0d", fwd_cnt, f0);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_out_wr", 64'(out_wr), 64'd0);
        chk("midrst_src", 64'(hdr_src_port), 64'd0);
        log_q.delete();
        push_w(ioq_word(16'd3, 16'd2, 16'd20), 8'hFF, 1, 1'b0);
        push_w(64'hF0, 8'h00, 2, 1'b0);
        push_w(64'hF1, 8'h08, 3, 1'b0);
        drain();
        chk("postrst_len", 64'(log_q.size()), 64'd2);
        if (log_q.size() == 2) chk("postrst_d0", log_q[0].d, 64'hF0);
        chk("postrst_src", 64'(hdr_src_port), 64'd2);
        chk("postrst_pkts", 64'(pkt_count), STATS ? 64'd1 : 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
